// File: rtl/pulse_line_driver_pkg.sv
// Shared line-driver definitions: FSM encodings
// and counter sizing helper.
package pulse_line_driver_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    HIGH = ST_HIGH,
    LOW  = ST_LOW
  } state_e;

  function automatic int cnt_w(
    input int h,
    input int l
  );
    int m;
    int w;
    m = (h > l) ? h : l;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pulse_line_driver_sat_counter.sv
// Saturating up/down counter with a registered
// overflow strobe on a rejected increment.
module sat_counter
  import pulse_line_driver_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         overflow_o
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q == MAX) ovf_d = 1'b1;
      else cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign count_o    = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/pulse_line_driver.sv
// Event line transmitter: stretches trig strobes
// into spaced pulses, queueing overlapping events.
module pulse_line_driver
  import pulse_line_driver_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 4,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  output logic              line,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int CW = cnt_w(HIGH_CYCLES, LOW_CYCLES);
  localparam logic [CW-1:0] H_LD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] L_LD = CW'(LOW_CYCLES - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          line_q;
  logic          busy_q;

  logic low_end;
  logic start;
  logic inc;
  logic dec;
  logic pend_nz;

  assign pend_nz = (pending != '0);
  assign low_end = (state_q == LOW) && (cnt_q == '0);

  // start = an event is consumed this cycle
  assign start = ((state_q == IDLE) && trig)
              || (low_end && (pend_nz || trig));

  assign inc = trig && !start;
  assign dec = start && !trig && pend_nz;

  sat_counter #(
    .W (PEND_W)
  ) u_pend (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (inc),
    .dec_i      (dec),
    .count_o    (pending),
    .overflow_o (overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (trig) begin
            state_q <= HIGH;
            cnt_q   <= H_LD;
            line_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        HIGH: begin
          if (cnt_q == '0) begin
            state_q <= LOW;
            cnt_q   <= L_LD;
            line_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        LOW: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (start) begin
            state_q <= HIGH;
            cnt_q   <= H_LD;
            line_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          line_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign line = line_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_pulse_line_driver.sv
// Scoreboard bench for pulse_line_driver with a
// pulse-schedule model of accepted events.
module tb_pulse_line_driver;

  localparam int H    = 4;
  localparam int L    = 4;
  localparam int PW   = 2;
  localparam int MAXP = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          trig = 1'b0;
  logic          line;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  always #5 clk = ~clk;

  pulse_line_driver #(
    .HIGH_CYCLES (H),
    .LOW_CYCLES  (L),
    .PEND_W      (PW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .trig     (trig),
    .line     (line),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   acc[$];
  int   exp_rise[$];
  int   ovf_at[$];
  int   last_rise = -1000;
  int   n_rise = 0;
  int   n_ovf = 0;
  logic prev_line = 1'b0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d",
               tag, cyc, got, exp);
    end
  endtask

  function automatic int m_line(input int d);
    foreach (acc[i])
      if (acc[i] <= d && d <= acc[i] + H - 1) return 1;
    return 0;
  endfunction

  function automatic int m_busy(input int d);
    foreach (acc[i])
      if (acc[i] <= d && d <= acc[i] + H + L - 1)
        return 1;
    return 0;
  endfunction

  function automatic int m_pend(input int d);
    int n;
    n = 0;
    foreach (acc[i]) if (acc[i] > d) n++;
    return n;
  endfunction

  function automatic int m_ovf(input int d);
    foreach (ovf_at[i]) if (ovf_at[i] == d) return 1;
    return 0;
  endfunction

  // Event at cycle c: rises at the earliest free slot,
  // dropped only if it cannot start and queue is full.
  task automatic model_event(input int c);
    int pend;
    int nr;
    bit st;
    pend = m_pend(c);
    st = 1'b0;
    foreach (acc[i]) if (acc[i] == c + 1) st = 1'b1;
    nr = last_rise + H + L;
    if (nr < c + 1) nr = c + 1;
    if (nr != c + 1 && !st && pend == MAXP) begin
      ovf_at.push_back(c + 1);
    end else begin
      acc.push_back(nr);
      exp_rise.push_back(nr);
      last_rise = nr;
    end
  endtask

  task automatic tick(input logic t);
    @(posedge clk);
    #1;
    cyc++;
    chk("line", line, m_line(cyc));
    chk("busy", busy, m_busy(cyc));
    chk("pending", pending, m_pend(cyc));
    chk("overflow", overflow, m_ovf(cyc));
    if (overflow) n_ovf++;
    if (line && !prev_line) begin
      n_rise++;
      if (exp_rise.size() == 0) chk("rise_unexp", cyc, -1);
      else chk("rise", cyc, exp_rise.pop_front());
    end
    prev_line = line;
    trig = t;
    if (t && rst_n) model_event(cyc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_rise.size() != 0 || m_busy(cyc + 1) != 0)
           && n < 200) begin
      tick(1'b0);
      n++;
    end
    chk("drain_q", exp_rise.size(), 0);
    repeat (3) tick(1'b0);
  endtask

  task automatic clear_model();
    acc.delete();
    exp_rise.delete();
    ovf_at.delete();
    last_rise = -1000;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // reset and idle
    repeat (3) tick(1'b0);
    rst_n = 1'b1;
    repeat (10) tick(1'b0);

    // single event
    tick(1'b1);
    repeat (12) tick(1'b0);
    drain();

    // burst of three
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    chk("burst_peak", pending, 2);
    drain();

    // overflow: five events back to back
    n_rise = 0;
    n_ovf = 0;
    repeat (5) tick(1'b1);
    drain();
    chk("ovf_count", n_ovf, 1);
    chk("ovf_pulses", n_rise, 4);

    // trig at LOW end with one pending
    tick(1'b1);
    tick(1'b1);
    repeat (6) tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    chk("coinc1_pend", pending, 1);
    chk("coinc1_line", line, 1);
    drain();

    // trig at LOW end with nothing pending
    tick(1'b1);
    repeat (7) tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    chk("coinc0_pend", pending, 0);
    chk("coinc0_line", line, 1);
    drain();

    // async reset mid-pulse with two pending
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    chk("pre_rst_pend", pending, 2);
    chk("pre_rst_line", line, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_line", line, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pend", pending, 0);
    chk("arst_ovf", overflow, 0);
    clear_model();
    prev_line = 1'b0;
    repeat (3) tick(1'b0);
    rst_n = 1'b1;
    n_rise = 0;
    repeat (25) tick(1'b0);
    chk("no_replay", n_rise, 0);

    // fresh event after reset
    tick(1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
